// File: rtl/note_sched_pkg.sv
// Shared types and song-word layout for the note scheduler.
package note_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_PLAY,
    S_DONE
  } state_t;

  // Song word: [15] EOS, [14:9] note, [8:3] duration, [2:0] amplitude
  localparam int unsigned EOS_BIT  = 15;
  localparam int unsigned NOTE_LSB = 9;
  localparam int unsigned DUR_LSB  = 3;
  localparam int unsigned AMP_LSB  = 0;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;
  localparam int unsigned AMP_W  = 3;
  localparam int unsigned ENV_W  = 6;

endpackage

// File: rtl/note_word_decode.sv
// Combinational song-word decode: field split, EOS/zero-duration flags and
// attack/decay clamping so that attack + decay never exceeds the duration.
module note_word_decode
  import note_sched_pkg::*;
(
  input  logic [15:0]       word,
  input  logic [ENV_W-1:0]  attack_in,
  input  logic [ENV_W-1:0]  decay_in,
  output logic              eos,
  output logic              dur_zero,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic [AMP_W-1:0]  amplitude,
  output logic [ENV_W-1:0]  attack,
  output logic [ENV_W-1:0]  decay
);

  logic [6:0] dur7;
  logic [6:0] att7;
  logic [6:0] rem7;
  logic [6:0] dec7;

  always_comb begin
    eos       = word[EOS_BIT];
    note      = word[NOTE_LSB +: NOTE_W];
    duration  = word[DUR_LSB +: DUR_W];
    amplitude = word[AMP_LSB +: AMP_W];
    dur_zero  = (duration == '0);

    // 7-bit sums keep the remainder arithmetic free of wrap-around
    dur7 = {1'b0, duration};
    att7 = ({1'b0, attack_in} < dur7) ? {1'b0, attack_in} : dur7;
    rem7 = dur7 - att7;
    dec7 = ({1'b0, decay_in} < rem7) ? {1'b0, decay_in} : rem7;

    attack = ENV_W'(att7);
    decay  = ENV_W'(dec7);
  end

endmodule

// File: rtl/note_scheduler.sv
// Song ROM walker: decodes note words, pulses new_note and counts beats to
// advance on note end. Define NOTE_SCHED_LOOP_EN to loop the song on EOS.
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic [ENV_W-1:0]  attack_in,
  input  logic [ENV_W-1:0]  decay_in,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              new_note,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic [AMP_W-1:0]  amplitude,
  output logic [ENV_W-1:0]  attack,
  output logic [ENV_W-1:0]  decay,
  output logic              song_done
);

  state_t state, state_nx;

  logic [DUR_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [ADDR_W-1:0] addr_nx, addr_inc;
  logic              last_addr;

  logic              new_note_nx, song_done_nx;
  logic [NOTE_W-1:0] note_nx;
  logic [DUR_W-1:0]  duration_nx;
  logic [AMP_W-1:0]  amplitude_nx;
  logic [ENV_W-1:0]  attack_nx, decay_nx;

  logic              d_eos, d_dur_zero;
  logic [NOTE_W-1:0] d_note;
  logic [DUR_W-1:0]  d_duration;
  logic [AMP_W-1:0]  d_amplitude;
  logic [ENV_W-1:0]  d_attack, d_decay;

  note_word_decode u_decode (
    .word      (rom_data),
    .attack_in (attack_in),
    .decay_in  (decay_in),
    .eos       (d_eos),
    .dur_zero  (d_dur_zero),
    .note      (d_note),
    .duration  (d_duration),
    .amplitude (d_amplitude),
    .attack    (d_attack),
    .decay     (d_decay)
  );

  assign cnt_inc   = cnt + DUR_W'(1);
  assign addr_inc  = rom_addr + ADDR_W'(1);
  assign last_addr = &rom_addr;

  always_comb begin
    state_nx     = state;
    addr_nx      = rom_addr;
    cnt_nx       = cnt;
    new_note_nx  = 1'b0;
    note_nx      = note;
    duration_nx  = duration;
    amplitude_nx = amplitude;
    attack_nx    = attack;
    decay_nx     = decay;
    song_done_nx = song_done;

    case (state)
      S_IDLE: begin
        addr_nx      = '0;
        cnt_nx       = '0;
        note_nx      = '0;
        duration_nx  = '0;
        amplitude_nx = '0;
        attack_nx    = '0;
        decay_nx     = '0;
        song_done_nx = 1'b0;
        if (play) state_nx = S_FETCH;
      end

      S_FETCH: begin
        // ends the looping-mode song_done pulse; never set here otherwise
        song_done_nx = 1'b0;
        state_nx     = S_WAIT;
      end

      S_WAIT: begin
        if (d_eos) begin
          song_done_nx = 1'b1;
`ifdef NOTE_SCHED_LOOP_EN
          addr_nx  = '0;
          state_nx = S_FETCH;
`else
          state_nx = S_DONE;
`endif
        end else if (d_dur_zero) begin
          if (last_addr) begin
            song_done_nx = 1'b1;
            state_nx     = S_DONE;
          end else begin
            addr_nx  = addr_inc;
            state_nx = S_FETCH;
          end
        end else begin
          note_nx      = d_note;
          duration_nx  = d_duration;
          amplitude_nx = d_amplitude;
          attack_nx    = d_attack;
          decay_nx     = d_decay;
          new_note_nx  = 1'b1;
          state_nx     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_nx   = '0;
        state_nx = S_PLAY;
      end

      S_PLAY: begin
        if (play && beat) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == duration) begin
            if (last_addr) begin
              song_done_nx = 1'b1;
              state_nx     = S_DONE;
            end else begin
              addr_nx  = addr_inc;
              state_nx = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        if (!play) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      cnt       <= '0;
      new_note  <= 1'b0;
      note      <= '0;
      duration  <= '0;
      amplitude <= '0;
      attack    <= '0;
      decay     <= '0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nx;
      rom_addr  <= addr_nx;
      cnt       <= cnt_nx;
      new_note  <= new_note_nx;
      note      <= note_nx;
      duration  <= duration_nx;
      amplitude <= amplitude_nx;
      attack    <= attack_nx;
      decay     <= decay_nx;
      song_done <= song_done_nx;
    end
  end

endmodule
